// File: rtl/matrix_stream_printer.sv
// -----------------------------------------------------------------------------
// matrix_stream_printer
//
// Purpose:
//   Streams a matrix of up to MAX_ROWS x MAX_COLS signed DATA_W-bit elements to
//   a UART number sender as a token sequence:
//     [header] [rows] [cols + newline] [data..., newline after each printed row]
//   Elements are fetched through a 1-cycle-latency read port. The matrix can be
//   printed in normal (row-major) or transposed (column-major) order, and a
//   print can be aborted at any time.
//
// Configuration:
//   PRINTER_CHECKSUM_EN (macro) - when defined, a DATA_W-bit wrap-around sum of
//   all data tokens is sent as one trailing token (with newline) before the
//   done pulse. When undefined there is no TAIL state and no accumulator.
//
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   synchronous active-high reset
//   start               in   1-cycle pulse, begin a print (ignored while busy)
//   abort               in   return to IDLE at the next edge, no printer_done
//   transpose           in   sampled with start; 1 = print A^T
//   mat_rows            in   row count, sampled with start (clamped to MAX_ROWS)
//   mat_cols            in   col count, sampled with start (clamped to MAX_COLS)
//   rd_row / rd_col     out  element read address
//   rd_en               out  read strobe; rd_data is valid the following cycle
//   rd_data             in   element read data
//   sender_data         out  token value, held stable until sender_done
//   sender_start        out  1-cycle pulse per token
//   sender_is_last_col  out  qualifies sender_start: append newline
//   sender_newline_only out  qualifies sender_start: newline only (never used
//                            by this printer, always 0)
//   sender_done         in   sender finished the current token
//   busy                out  high while not IDLE
//   printer_done        out  1-cycle pulse after the final token completes
//   dbg_state           out  current FSM state encoding
//
// Handshake: each send state presents sender_data and pulses sender_start
// once, then holds sender_data and waits for sender_done. Only a sender_done
// seen while a token is outstanding advances the FSM; any other sender_done
// is ignored.
// -----------------------------------------------------------------------------
module matrix_stream_printer #(
  parameter int DATA_W     = 8,
  parameter int MAX_ROWS   = 5,
  parameter int MAX_COLS   = 5,
  parameter int HEADER_VAL = 170,
  parameter int HEADER_EN  = 1,
  localparam int RW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
  localparam int CW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              transpose,
  input  logic [RW-1:0]     mat_rows,
  input  logic [CW-1:0]     mat_cols,
  output logic [RW-1:0]     rd_row,
  output logic [CW-1:0]     rd_col,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sender_data,
  output logic              sender_start,
  output logic              sender_is_last_col,
  output logic              sender_newline_only,
  input  logic              sender_done,
  output logic              busy,
  output logic              printer_done,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HEAD  = 4'd1,
    S_DIM_R = 4'd2,
    S_DIM_C = 4'd3,
    S_FETCH = 4'd4,
    S_SEND  = 4'd5,
    S_WAIT  = 4'd6,
`ifdef PRINTER_CHECKSUM_EN
    S_TAIL  = 4'd7,
`endif
    S_DONE  = 4'd8
  } state_e;

  localparam logic [RW-1:0]     MAX_R = RW'(MAX_ROWS);
  localparam logic [CW-1:0]     MAX_C = CW'(MAX_COLS);
  localparam logic [DATA_W-1:0] HDR   = DATA_W'(HEADER_VAL);

  state_e              state_q, state_d;
  logic [RW-1:0]       rows_q, rows_d;
  logic [CW-1:0]       cols_q, cols_d;
  logic                tr_q, tr_d;
  logic [RW-1:0]       r_q, r_d;
  logic [CW-1:0]       c_q, c_d;
  logic                sent_q, sent_d;      // token of the current send state issued
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic                sstart_q, sstart_d;
  logic                slast_q, slast_d;
`ifdef PRINTER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  // Last valid index on each axis (only meaningful for non-zero dims).
  logic [RW-1:0] r_max;
  logic [CW-1:0] c_max;
  logic          row_last;   // current element ends a printed row
  logic          elem_last;  // current element is the final one

  assign r_max     = rows_q - RW'(1);
  assign c_max     = cols_q - CW'(1);
  // Transposed: a printed row is a source column, so it ends on the last row.
  assign row_last  = tr_q ? (r_q == r_max) : (c_q == c_max);
  assign elem_last = (r_q == r_max) && (c_q == c_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      tr_q     <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
      sent_q   <= 1'b0;
      sdata_q  <= '0;
      sstart_q <= 1'b0;
      slast_q  <= 1'b0;
`ifdef PRINTER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      tr_q     <= tr_d;
      r_q      <= r_d;
      c_q      <= c_d;
      sent_q   <= sent_d;
      sdata_q  <= sdata_d;
      sstart_q <= sstart_d;
      slast_q  <= slast_d;
`ifdef PRINTER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    tr_d     = tr_q;
    r_d      = r_q;
    c_d      = c_q;
    sent_d   = sent_q;
    sdata_d  = sdata_q;
    sstart_d = 1'b0;
    slast_d  = 1'b0;
`ifdef PRINTER_CHECKSUM_EN
    sum_d    = sum_q;
`endif

    // Abort has priority over everything, including a start seen in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      sent_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rows_d  = (mat_rows > MAX_R) ? MAX_R : mat_rows;
            cols_d  = (mat_cols > MAX_C) ? MAX_C : mat_cols;
            tr_d    = transpose;
            r_d     = '0;
            c_d     = '0;
            sent_d  = 1'b0;
`ifdef PRINTER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = (HEADER_EN != 0) ? S_HEAD : S_DIM_R;
          end
        end

        S_HEAD: begin
          if (!sent_q) begin
            sdata_d  = HDR;
            sstart_d = 1'b1;
            sent_d   = 1'b1;
          end else if (sender_done) begin
            sent_d  = 1'b0;
            state_d = S_DIM_R;
          end
        end

        // First dimension token: rows normally, cols when transposed.
        S_DIM_R: begin
          if (!sent_q) begin
            sdata_d  = tr_q ? DATA_W'(cols_q) : DATA_W'(rows_q);
            sstart_d = 1'b1;
            sent_d   = 1'b1;
          end else if (sender_done) begin
            sent_d  = 1'b0;
            state_d = S_DIM_C;
          end
        end

        // Second dimension token closes the dimension line.
        S_DIM_C: begin
          if (!sent_q) begin
            sdata_d  = tr_q ? DATA_W'(rows_q) : DATA_W'(cols_q);
            sstart_d = 1'b1;
            slast_d  = 1'b1;
            sent_d   = 1'b1;
          end else if (sender_done) begin
            sent_d  = 1'b0;
            // An empty matrix has no data and no checksum line.
            state_d = ((rows_q == '0) || (cols_q == '0)) ? S_DONE : S_FETCH;
          end
        end

        S_FETCH: begin
          state_d = S_SEND;
        end

        // rd_data belongs to the address strobed in FETCH.
        S_SEND: begin
          sdata_d  = rd_data;
          sstart_d = 1'b1;
          slast_d  = row_last;
`ifdef PRINTER_CHECKSUM_EN
          sum_d    = sum_q + rd_data;
`endif
          state_d  = S_WAIT;
        end

        S_WAIT: begin
          if (sender_done) begin
            if (elem_last) begin
`ifdef PRINTER_CHECKSUM_EN
              state_d = S_TAIL;
`else
              state_d = S_DONE;
`endif
            end else begin
              // Inner index wraps to 0 and carries into the outer index.
              if (tr_q) begin
                if (r_q == r_max) begin
                  r_d = '0;
                  c_d = c_q + CW'(1);
                end else begin
                  r_d = r_q + RW'(1);
                end
              end else begin
                if (c_q == c_max) begin
                  c_d = '0;
                  r_d = r_q + RW'(1);
                end else begin
                  c_d = c_q + CW'(1);
                end
              end
              state_d = S_FETCH;
            end
          end
        end

`ifdef PRINTER_CHECKSUM_EN
        S_TAIL: begin
          if (!sent_q) begin
            sdata_d  = sum_q;
            sstart_d = 1'b1;
            slast_d  = 1'b1;
            sent_d   = 1'b1;
          end else if (sender_done) begin
            sent_d  = 1'b0;
            state_d = S_DONE;
          end
        end
`endif

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign rd_row              = r_q;
  assign rd_col              = c_q;
  assign rd_en               = (state_q == S_FETCH);
  assign sender_data         = sdata_q;
  assign sender_start        = sstart_q;
  assign sender_is_last_col  = slast_q;
  assign sender_newline_only = 1'b0;
  assign busy                = (state_q != S_IDLE);
  assign printer_done        = (state_q == S_DONE);
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_matrix_stream_printer.sv
// -----------------------------------------------------------------------------
// tb_matrix_stream_printer
//
// Two printer instances share one clock and reset: u_dut0 with the header
// token enabled, u_dut1 without it. Only one instance prints at a time, so a
// single expected-token queue and a single expected-address queue serve both.
// A memory model answers reads with one cycle of latency, and a sender model
// answers every sender_start with sender_done a few cycles later.
// -----------------------------------------------------------------------------
module tb_matrix_stream_printer;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef PRINTER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  // DUT-side signals, index 0 = u_dut0, index 1 = u_dut1
  logic       start_s [2];
  logic       abort_s [2];
  logic       tr_s    [2];
  logic [2:0] rows_s  [2];
  logic [2:0] cols_s  [2];
  logic [2:0] rd_row_s[2];
  logic [2:0] rd_col_s[2];
  logic       rd_en_s [2];
  logic [7:0] rd_data_s[2];
  logic [7:0] sdata_s [2];
  logic       sstart_s[2];
  logic       slast_s [2];
  logic       snl_s   [2];
  logic       sdone_s [2];
  logic       busy_s  [2];
  logic       pdone_s [2];
  logic [3:0] dbg_s   [2];

  logic model_done0 = 1'b0, model_done1 = 1'b0;
  logic stray_done0 = 1'b0;
  assign sdone_s[0] = model_done0 | stray_done0;
  assign sdone_s[1] = model_done1;

  matrix_stream_printer #(.HEADER_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
    .transpose(tr_s[0]), .mat_rows(rows_s[0]), .mat_cols(cols_s[0]),
    .rd_row(rd_row_s[0]), .rd_col(rd_col_s[0]), .rd_en(rd_en_s[0]),
    .rd_data(rd_data_s[0]), .sender_data(sdata_s[0]),
    .sender_start(sstart_s[0]), .sender_is_last_col(slast_s[0]),
    .sender_newline_only(snl_s[0]), .sender_done(sdone_s[0]),
    .busy(busy_s[0]), .printer_done(pdone_s[0]), .dbg_state(dbg_s[0])
  );

  matrix_stream_printer #(.HEADER_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
    .transpose(tr_s[1]), .mat_rows(rows_s[1]), .mat_cols(cols_s[1]),
    .rd_row(rd_row_s[1]), .rd_col(rd_col_s[1]), .rd_en(rd_en_s[1]),
    .rd_data(rd_data_s[1]), .sender_data(sdata_s[1]),
    .sender_start(sstart_s[1]), .sender_is_last_col(slast_s[1]),
    .sender_newline_only(snl_s[1]), .sender_done(sdone_s[1]),
    .busy(busy_s[1]), .printer_done(pdone_s[1]), .dbg_state(dbg_s[1])
  );

  // scoreboard state
  // exp_q entry: {done_marker, is_data, newline_only, last_col, data[7:0]}
  logic [11:0] exp_q[$];
  logic [5:0]  addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tokens_seen = 0;
  int dones_seen  = 0;
  int last_rd[2];
  logic [7:0] mem [0:4][0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: data for the address strobed this cycle appears next cycle
  initial begin
    logic e0, e1;
    logic [2:0] r0, c0, r1, c1;
    rd_data_s[0] = '0;
    rd_data_s[1] = '0;
    forever begin
      @(posedge clk);
      e0 = rd_en_s[0]; r0 = rd_row_s[0]; c0 = rd_col_s[0];
      e1 = rd_en_s[1]; r1 = rd_row_s[1]; c1 = rd_col_s[1];
      #1;
      if (e0) rd_data_s[0] = (r0 < 5 && c0 < 5) ? mem[r0][c0] : 8'hxx;
      if (e1) rd_data_s[1] = (r1 < 5 && c1 < 5) ? mem[r1][c1] : 8'hxx;
    end
  end

  // sender models: done three cycles after each start
  initial forever begin
    @(negedge clk);
    if (sstart_s[0]) begin
      repeat (3) @(posedge clk);
      #1 model_done0 = 1'b1;
      @(posedge clk);
      #1 model_done0 = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (sstart_s[1]) begin
      repeat (3) @(posedge clk);
      #1 model_done1 = 1'b1;
      @(posedge clk);
      #1 model_done1 = 1'b0;
    end
  end

  // monitor: pops expectations whenever a DUT presents an output event
  initial forever begin
    logic [11:0] e;
    logic [5:0]  a;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rd_en_s[k]) begin
        last_rd[k] = cyc;
        if (addr_q.size() == 0) flag_fail("rd_addr_extra");
        else begin
          a = addr_q.pop_front();
          check("rd_addr", {26'd0, rd_row_s[k], rd_col_s[k]}, {26'd0, a});
        end
      end
      if (sstart_s[k]) begin
        tokens_seen++;
        if (exp_q.size() == 0) flag_fail("token_extra");
        else begin
          e = exp_q.pop_front();
          check("token", {20'd0, 1'b0, e[10], snl_s[k], slast_s[k], sdata_s[k]}, {20'd0, e});
          if (e[10]) check("elem_latency", cyc - last_rd[k], 2);
        end
      end
      if (pdone_s[k]) begin
        dones_seen++;
        if (exp_q.size() == 0) flag_fail("printer_done_extra");
        else begin
          e = exp_q.pop_front();
          check("printer_done", {20'd0, e}, 32'h800);
        end
      end
    end
  end

  // driver tasks
  task automatic push_tok(input logic [7:0] d, input logic last, input logic is_data);
    exp_q.push_back({1'b0, is_data, 1'b0, last, d});
  endtask

  task automatic push_data(input logic [2:0] r, input logic [2:0] c, input logic last);
    addr_q.push_back({r, c});
    push_tok(mem[r][c], last, 1'b1);
  endtask

  task automatic push_end(input logic [7:0] sum);
    if (CS_EN) push_tok(sum, 1'b1, 1'b0);
    exp_q.push_back(12'h800);
  endtask

  task automatic start_print(input int k, input logic [2:0] r, input logic [2:0] c, input logic t);
    @(posedge clk);
    #1;
    start_s[k] = 1'b1; rows_s[k] = r; cols_s[k] = c; tr_s[k] = t;
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
    check("busy_after_start", {31'd0, busy_s[k]}, 1);
  endtask

  task automatic wait_done(input int k, input int base);
    int cnt = 0;
    while (dones_seen <= base && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) flag_fail("wait_done_timeout");
    @(posedge clk);
    #1;
    check("busy_after_done", {31'd0, busy_s[k]}, 0);
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_tokens(input int n);
    int cnt = 0;
    while (tokens_seen < n && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 2000) flag_fail("wait_tokens_timeout");
  endtask

  task automatic load_2x3();
    mem[0][0] = 8'd1; mem[0][1] = 8'd2; mem[0][2] = 8'd3;
    mem[1][0] = 8'd4; mem[1][1] = 8'd5; mem[1][2] = 8'd6;
  endtask

  task automatic expect_2x3_normal();
    push_tok(8'd170, 1'b0, 1'b0);
    push_tok(8'd2, 1'b0, 1'b0);
    push_tok(8'd3, 1'b1, 1'b0);
    push_data(0, 0, 0); push_data(0, 1, 0); push_data(0, 2, 1);
    push_data(1, 0, 0); push_data(1, 1, 0); push_data(1, 2, 1);
    push_end(8'd21);
  endtask

  initial begin
    int base;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 0; abort_s[k] = 0; tr_s[k] = 0; rows_s[k] = 0; cols_s[k] = 0;
      last_rd[k] = 0;
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mem[r][c] = 8'd0;

    // reset values
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy",   {31'd0, busy_s[k]}, 0);
      check("rst_sstart", {31'd0, sstart_s[k]}, 0);
      check("rst_pdone",  {31'd0, pdone_s[k]}, 0);
      check("rst_rd_en",  {31'd0, rd_en_s[k]}, 0);
      check("rst_sdata",  {24'd0, sdata_s[k]}, 0);
      check("rst_rd_addr", {26'd0, rd_row_s[k], rd_col_s[k]}, 0);
      check("rst_state",  {28'd0, dbg_s[k]}, 0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 2x3 normal order
    load_2x3();
    expect_2x3_normal();
    base = dones_seen;
    start_print(0, 3'd2, 3'd3, 1'b0);
    wait_done(0, base);

    // 2x3 transposed: dims swapped, column-major reads
    push_tok(8'd170, 1'b0, 1'b0);
    push_tok(8'd3, 1'b0, 1'b0);
    push_tok(8'd2, 1'b1, 1'b0);
    push_data(0, 0, 0); push_data(1, 0, 1);
    push_data(0, 1, 0); push_data(1, 1, 1);
    push_data(0, 2, 0); push_data(1, 2, 1);
    push_end(8'd21);
    base = dones_seen;
    start_print(0, 3'd2, 3'd3, 1'b1);
    wait_done(0, base);

    // 1x1 [-128] without header
    mem[0][0] = 8'h80;
    push_tok(8'd1, 1'b0, 1'b0);
    push_tok(8'd1, 1'b1, 1'b0);
    push_data(0, 0, 1);
    push_end(8'h80);
    base = dones_seen;
    start_print(1, 3'd1, 3'd1, 1'b0);
    wait_done(1, base);

    // abort while the second data token of a 3x3 is outstanding
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mem[r][c] = 8'(r * 3 + c + 1);
    push_tok(8'd170, 1'b0, 1'b0);
    push_tok(8'd3, 1'b0, 1'b0);
    push_tok(8'd3, 1'b1, 1'b0);
    push_data(0, 0, 0); push_data(0, 1, 0);
    base = tokens_seen;
    start_print(0, 3'd3, 3'd3, 1'b0);
    wait_tokens(base + 5);
    @(posedge clk);
    #1 abort_s[0] = 1'b1;
    @(posedge clk);
    #1 abort_s[0] = 1'b0;
    check("busy_after_abort", {31'd0, busy_s[0]}, 0);
    repeat (20) @(posedge clk);
    check("abort_tokens_left", exp_q.size(), 0);
    check("abort_addr_left", addr_q.size(), 0);

    // a fresh print after abort is complete and correct
    load_2x3();
    expect_2x3_normal();
    base = dones_seen;
    start_print(0, 3'd2, 3'd3, 1'b0);
    wait_done(0, base);

    // stray sender_done in IDLE, then a second start mid-print
    @(posedge clk);
    #1 stray_done0 = 1'b1;
    @(posedge clk);
    #1 stray_done0 = 1'b0;
    check("stray_done_busy", {31'd0, busy_s[0]}, 0);
    check("stray_done_state", {28'd0, dbg_s[0]}, 0);
    expect_2x3_normal();
    base = dones_seen;
    start_print(0, 3'd2, 3'd3, 1'b0);
    wait_tokens(tokens_seen + 4);
    @(posedge clk);
    #1;
    start_s[0] = 1'b1; tr_s[0] = 1'b1; rows_s[0] = 3'd1; cols_s[0] = 3'd1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    wait_done(0, base);
    repeat (20) @(posedge clk);
    check("restart_tokens_left", exp_q.size(), 0);

    // 2x2 of 100: checksum wraps to 144
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        mem[r][c] = 8'd100;
    push_tok(8'd170, 1'b0, 1'b0);
    push_tok(8'd2, 1'b0, 1'b0);
    push_tok(8'd2, 1'b1, 1'b0);
    push_data(0, 0, 0); push_data(0, 1, 1);
    push_data(1, 0, 0); push_data(1, 1, 1);
    push_end(8'd144);
    base = dones_seen;
    start_print(0, 3'd2, 3'd2, 1'b0);
    wait_done(0, base);

    // rows above MAX clamp to 5; single column, every element ends a row
    for (int r = 0; r < 5; r++) mem[r][0] = 8'(10 * (r + 1));
    push_tok(8'd170, 1'b0, 1'b0);
    push_tok(8'd5, 1'b0, 1'b0);
    push_tok(8'd1, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) push_data(3'(r), 0, 1);
    push_end(8'd150);
    base = dones_seen;
    start_print(0, 3'd7, 3'd1, 1'b0);
    wait_done(0, base);

    // zero rows: header and dims only, no data and no checksum
    push_tok(8'd170, 1'b0, 1'b0);
    push_tok(8'd0, 1'b0, 1'b0);
    push_tok(8'd3, 1'b1, 1'b0);
    exp_q.push_back(12'h800);
    base = dones_seen;
    start_print(0, 3'd0, 3'd3, 1'b0);
    wait_done(0, base);

    check("final_tokens_left", exp_q.size(), 0);
    check("final_addr_left", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
